// File: rtl/pixel_fifo_pkg.sv
// Shared definitions for the camera-to-FIFO pixel writer.
//   PIXEL_BITS / SOF_BIT / EOL_BIT : layout of the FIFO word {eol, sof, pixel}
//   state_e                        : capture FSM encoding
//   sat_inc16                      : saturating 16-bit increment for status counters
package pixel_fifo_pkg;

   localparam int unsigned PIXEL_BITS = 16;
   localparam int unsigned SOF_BIT    = 16;
   localparam int unsigned EOL_BIT    = 17;
   localparam int unsigned COUNT_BITS = 16;

   // Fixed encodings so the state value is stable across tools and debug probes.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SYNC   = 2'd1,
      ACTIVE = 2'd2
   } state_e;

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [COUNT_BITS-1:0] sat_inc16(input logic [COUNT_BITS-1:0] value);
      if (value == '1) begin
         return value;
      end
      return value + COUNT_BITS'(1);
   endfunction

endpackage

// File: rtl/byte_pair_packer.sv
// Pairs consecutive camera bytes into 16-bit pixels.
//   write_clock, reset : pixel clock, async active-high reset
//   restart            : forces byte phase back to the high byte
//   byte_valid         : a camera byte is present this cycle
//   byte_data          : camera byte
//   byte_phase         : 0 = next byte is high byte, 1 = next byte is low byte
//   pixel_done_c       : combinational pulse on the edge sampling the low byte
//   pixel_c            : assembled pixel, valid with pixel_done_c
module byte_pair_packer
   import pixel_fifo_pkg::*;
(
   input  logic                  write_clock,
   input  logic                  reset,
   input  logic                  restart,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_phase,
   output logic                  pixel_done_c,
   output logic [PIXEL_BITS-1:0] pixel_c
);

   logic [7:0] hi_byte;
   logic       take;

   assign take = byte_valid & ~restart;

   // Phase toggle and high-byte capture.
   always_ff @(posedge write_clock or posedge reset) begin
      if (reset) begin
         byte_phase <= 1'b0;
         hi_byte    <= '0;
      end else if (restart) begin
         byte_phase <= 1'b0;
      end else if (take) begin
         byte_phase <= ~byte_phase;
         if (!byte_phase) begin
            hi_byte <= byte_data;
         end
      end
   end

   // The low byte is used straight from the input so the pixel is complete on its own edge.
   assign pixel_done_c = take & byte_phase;
   assign pixel_c      = {hi_byte, byte_data};

endmodule

// File: rtl/pixel_fifo_writer.sv
// Captures camera pixels (two bytes per pixel) and pushes {eol, sof, pixel} words into a FIFO.
//   write_clock, reset   : camera pixel clock, async active-high reset
//   vsync, href          : frame sync (high between frames), line valid
//   cam_data             : camera byte
//   full                 : FIFO full flag
//   clear_status         : clears overflow, line_error, drop_count
//   write_en, write_data : FIFO push strobe (combinational on full) and word
//   frame_count          : completed frames, wrapping
//   drop_count           : dropped pixels, saturating
//   overflow, line_error : sticky status flags
module pixel_fifo_writer
   import pixel_fifo_pkg::*;
#(
   parameter int unsigned LINE_PIXELS = 640,
   parameter int unsigned WIDTH       = 18
) (
   input  logic             reset,
   input  logic             write_clock,
   input  logic             vsync,
   input  logic             href,
   input  logic [7:0]       cam_data,
   input  logic             full,
   input  logic             clear_status,
   output logic             write_en,
   output logic [WIDTH-1:0] write_data,
   output logic [15:0]      frame_count,
   output logic [15:0]      drop_count,
   output logic             overflow,
   output logic             line_error
);

   // One spare bit so an over-long line cannot alias back to a legal count.
   localparam int unsigned      IDX_BITS  = $clog2(LINE_PIXELS + 1) + 1;
   localparam logic [IDX_BITS-1:0] LAST_IDX  = IDX_BITS'(LINE_PIXELS - 1);
   localparam logic [IDX_BITS-1:0] FULL_LINE = IDX_BITS'(LINE_PIXELS);

   state_e                  state;
   state_e                  state_next;
   logic                    frame_begin;
   logic                    frame_done;
   logic                    active;
   logic                    href_d;
   logic                    line_end;
   logic                    bad_line;
   logic                    packer_restart;
   logic                    byte_phase;
   logic                    pixel_done_c;
   logic [PIXEL_BITS-1:0]   pixel_c;
   logic [IDX_BITS-1:0]     pix_idx;
   logic                    sof_pending;
   logic                    pend_valid;
   logic [WIDTH-1:0]        pend_word;
   logic [WIDTH-1:0]        new_word;
   logic                    accept;
   logic                    drop;

   // FSM state register.
   always_ff @(posedge write_clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state plus frame boundary pulses.
   always_comb begin
      state_next  = state;
      frame_begin = 1'b0;
      frame_done  = 1'b0;
      case (state)
         IDLE: begin
            if (vsync) begin
               state_next = SYNC;
            end
         end
         SYNC: begin
            if (!vsync) begin
               state_next  = ACTIVE;
               frame_begin = 1'b1;
            end
         end
         ACTIVE: begin
            if (vsync) begin
               state_next = SYNC;
               frame_done = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign active         = (state == ACTIVE);
   assign line_end       = active & href_d & ~href;
   assign packer_restart = ~active | line_end;
   assign bad_line       = line_end & (byte_phase | (pix_idx != FULL_LINE));

   // href history for falling-edge detection.
   always_ff @(posedge write_clock or posedge reset) begin
      if (reset) begin
         href_d <= 1'b0;
      end else begin
         href_d <= href;
      end
   end

   byte_pair_packer u_packer (
      .write_clock  (write_clock),
      .reset        (reset),
      .restart      (packer_restart),
      .byte_valid   (href & active),
      .byte_data    (cam_data),
      .byte_phase   (byte_phase),
      .pixel_done_c (pixel_done_c),
      .pixel_c      (pixel_c)
   );

   // Pixel index within the line; counts dropped pixels too, saturates instead of wrapping.
   always_ff @(posedge write_clock or posedge reset) begin
      if (reset) begin
         pix_idx <= '0;
      end else if (packer_restart) begin
         pix_idx <= '0;
      end else if (pixel_done_c && (pix_idx != '1)) begin
         pix_idx <= pix_idx + IDX_BITS'(1);
      end
   end

   // Start-of-frame marker waits for the first completed pixel of the frame.
   always_ff @(posedge write_clock or posedge reset) begin
      if (reset) begin
         sof_pending <= 1'b0;
      end else if (frame_begin) begin
         sof_pending <= 1'b1;
      end else if (pixel_done_c) begin
         sof_pending <= 1'b0;
      end
   end

   // FIFO word for the pixel completing this cycle.
   always_comb begin
      new_word                  = '0;
      new_word[PIXEL_BITS-1:0]  = pixel_c;
      new_word[SOF_BIT]         = sof_pending;
      new_word[EOL_BIT]         = (pix_idx == LAST_IDX);
   end

   assign write_en = pend_valid & ~full;
   assign accept   = pixel_done_c & (~pend_valid | write_en);
   assign drop     = pixel_done_c & pend_valid & ~write_en;

   // One-entry pending register; a word pushing out frees the slot for a same-edge load.
   always_ff @(posedge write_clock or posedge reset) begin
      if (reset) begin
         pend_valid <= 1'b0;
         pend_word  <= '0;
      end else if (accept) begin
         pend_valid <= 1'b1;
         pend_word  <= new_word;
      end else if (write_en) begin
         pend_valid <= 1'b0;
      end
   end

   assign write_data = pend_word;

   // Status: a drop on the clear cycle wins and is counted after the clear.
   always_ff @(posedge write_clock or posedge reset) begin
      if (reset) begin
         overflow    <= 1'b0;
         drop_count  <= '0;
         line_error  <= 1'b0;
         frame_count <= '0;
      end else begin
         if (drop) begin
            overflow   <= 1'b1;
            drop_count <= clear_status ? 16'd1 : sat_inc16(drop_count);
         end else if (clear_status) begin
            overflow   <= 1'b0;
            drop_count <= '0;
         end

         if (bad_line) begin
            line_error <= 1'b1;
         end else if (clear_status) begin
            line_error <= 1'b0;
         end

         if (frame_done) begin
            frame_count <= frame_count + 16'd1;
         end
      end
   end

endmodule
